// File: rtl/kbd_event_ctrl.sv
// Keyboard event controller: decodes PS/2 make/break/E0 scan-code bytes, suppresses
// typematic repeats, pulses on new presses, and presents events on a one-entry valid/ready slot.
module kbd_event_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_make,
  output logic       key_down,
  output logic       press_pulse,
  output logic [7:0] h0,
  output logic [7:0] h1
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t     state;
  logic [7:0] held_code;
  logic       held_ext;

  logic       accept;
  logic       is_e0;
  logic       is_f0;
  logic       code_ext;
  logic       code_brk;
  logic       held_match;

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 8'b00000011;
      4'h1: glyph = 8'b10011111;
      4'h2: glyph = 8'b00100101;
      4'h3: glyph = 8'b00001101;
      4'h4: glyph = 8'b10011001;
      4'h5: glyph = 8'b01001001;
      4'h6: glyph = 8'b01000001;
      4'h7: glyph = 8'b00011111;
      4'h8: glyph = 8'b00000001;
      4'h9: glyph = 8'b00001001;
      4'hA: glyph = 8'b00010001;
      4'hB: glyph = 8'b11000001;
      4'hC: glyph = 8'b01100011;
      4'hD: glyph = 8'b10000101;
      4'hE: glyph = 8'b01100001;
      default: glyph = 8'b01110001;
    endcase
  endfunction

  // A pop frees the slot in the same cycle, so the receiver never has to wait a bubble.
  assign byte_ready = !evt_valid || evt_ready;
  assign accept     = byte_valid && byte_ready;
  assign is_e0      = (byte_data == 8'hE0);
  assign is_f0      = (byte_data == 8'hF0);
  assign code_ext   = (state == EXT) || (state == EXT_BRK);
  assign code_brk   = (state == BRK) || (state == EXT_BRK);
  assign held_match = key_down && ({held_ext, held_code} == {code_ext, byte_data});

  assign h0 = key_down ? glyph(held_code[3:0]) : 8'hFF;
  assign h1 = key_down ? glyph(held_code[7:4]) : 8'hFF;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      key_down    <= 1'b0;
      held_code   <= 8'h00;
      held_ext    <= 1'b0;
      evt_valid   <= 1'b0;
      evt_code    <= 8'h00;
      evt_ext     <= 1'b0;
      evt_make    <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      if (evt_valid && evt_ready)
        evt_valid <= 1'b0;
      if (accept) begin
        if (is_e0) begin
          state <= code_brk ? EXT_BRK : EXT;
        end else if (is_f0) begin
          state <= code_ext ? EXT_BRK : BRK;
        end else begin
          state <= IDLE;
          if (code_brk) begin
            evt_valid <= 1'b1;
            evt_code  <= byte_data;
            evt_ext   <= code_ext;
            evt_make  <= 1'b0;
            if (held_match)
              key_down <= 1'b0;
          end else if (!held_match) begin
            // A make that matches the held key is a typematic repeat and is swallowed.
            held_code   <= byte_data;
            held_ext    <= code_ext;
            key_down    <= 1'b1;
            press_pulse <= 1'b1;
            evt_valid   <= 1'b1;
            evt_code    <= byte_data;
            evt_ext     <= code_ext;
            evt_make    <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Self-checking bench for kbd_event_ctrl: a prefix-flag model checked every cycle,
// plus directed literal expectations pinning key scenarios.
module tb_kbd_event_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_make;
  logic       key_down;
  logic       press_pulse;
  logic [7:0] h0;
  logic [7:0] h1;

  int checks = 0;
  int fails  = 0;
  int pulse_cnt = 0;
  int pop_cnt   = 0;

  kbd_event_ctrl dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_make(evt_make),
    .key_down(key_down), .press_pulse(press_pulse), .h0(h0), .h1(h1)
  );

  always #5 clk = ~clk;

  logic [7:0] glyph_tab [16] = '{
    8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
    8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
    8'b00000001, 8'b00001001, 8'b00010001, 8'b11000001,
    8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001
  };

  // Behavioural model: pending prefix flags plus the held key and the one-entry slot.
  bit       m_on = 0;
  bit       m_valid, m_ext, m_make, m_down, m_pulse, m_pre_ext, m_pre_brk;
  bit [7:0] m_code;
  bit [8:0] m_held;

  always @(posedge clk) begin
    bit acc;
    bit rep;
    if (rst === 1'b0) begin
      m_on = 1; m_valid = 0; m_ext = 0; m_make = 0; m_code = 0; m_down = 0;
      m_pulse = 0; m_held = 0; m_pre_ext = 0; m_pre_brk = 0;
    end else if (m_on) begin
      acc = byte_valid && (!m_valid || evt_ready);
      m_pulse = 0;
      if (m_valid && evt_ready) m_valid = 0;
      if (acc) begin
        if (byte_data == 8'hE0) m_pre_ext = 1;
        else if (byte_data == 8'hF0) m_pre_brk = 1;
        else begin
          rep = m_down && (m_held == {m_pre_ext, byte_data});
          if (m_pre_brk) begin
            m_valid = 1; m_code = byte_data; m_ext = m_pre_ext; m_make = 0;
            if (rep) m_down = 0;
          end else if (!rep) begin
            m_held = {m_pre_ext, byte_data}; m_down = 1; m_pulse = 1;
            m_valid = 1; m_code = byte_data; m_ext = m_pre_ext; m_make = 1;
          end
          m_pre_ext = 0; m_pre_brk = 0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (m_on) begin
      checkOutput("byte_ready", byte_ready, !m_valid || evt_ready);
      checkOutput("evt_valid", evt_valid, m_valid);
      if (m_valid) begin
        checkOutput("evt_code", evt_code, m_code);
        checkOutput("evt_ext", evt_ext, m_ext);
        checkOutput("evt_make", evt_make, m_make);
      end
      checkOutput("key_down", key_down, m_down);
      checkOutput("press_pulse", press_pulse, m_pulse);
      checkOutput("h0", h0, m_down ? glyph_tab[m_held[3:0]] : 8'hFF);
      checkOutput("h1", h1, m_down ? glyph_tab[m_held[7:4]] : 8'hFF);
      if (press_pulse === 1'b1) pulse_cnt++;
      if (evt_valid === 1'b1 && evt_ready === 1'b1) pop_cnt++;
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    int e0;
    rst = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; evt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_h0", h0, 8'hFF);
    checkOutput("rst_h1", h1, 8'hFF);
    checkOutput("rst_ready", byte_ready, 1);
    checkOutput("rst_valid", evt_valid, 0);
    rst = 1'b1;

    applyStimulus(8'h1C);
    checkOutput("mk1c_evt", {evt_valid, evt_code, evt_ext, evt_make}, {1'b1, 8'h1C, 1'b0, 1'b1});
    checkOutput("mk1c_pulse", press_pulse, 1);
    checkOutput("mk1c_h0", h0, 8'b01100011);
    checkOutput("mk1c_h1", h1, 8'b10011111);
    idle(1);
    checkOutput("pulse_once", press_pulse, 0);

    p0 = pulse_cnt; e0 = pop_cnt;
    applyStimulus(8'h1C); applyStimulus(8'h1C);
    idle(2);
    checkOutput("repeat_pulses", pulse_cnt - p0, 0);
    checkOutput("repeat_events", pop_cnt - e0, 0);

    applyStimulus(8'hF0);
    checkOutput("prefix_noevt", evt_valid, 0);
    applyStimulus(8'h1C);
    checkOutput("brk1c_evt", {evt_valid, evt_code, evt_ext, evt_make}, {1'b1, 8'h1C, 1'b0, 1'b0});
    checkOutput("brk1c_down", key_down, 0);
    checkOutput("brk1c_h0", h0, 8'hFF);

    applyStimulus(8'hE0); applyStimulus(8'h75);
    checkOutput("mk_e075", {evt_valid, evt_code, evt_ext, evt_make}, {1'b1, 8'h75, 1'b1, 1'b1});
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
    checkOutput("brk_e075", {evt_valid, evt_code, evt_ext, evt_make}, {1'b1, 8'h75, 1'b1, 1'b0});
    checkOutput("brk_e075_down", key_down, 0);

    p0 = pulse_cnt;
    applyStimulus(8'h1C); applyStimulus(8'h32);
    idle(1);
    checkOutput("two_pulses", pulse_cnt - p0, 2);
    applyStimulus(8'hF0); applyStimulus(8'h1C);
    checkOutput("stale_brk_evt", {evt_valid, evt_code, evt_make}, {1'b1, 8'h1C, 1'b0});
    checkOutput("stale_brk_down", key_down, 1);
    checkOutput("held32_h0", h0, 8'b00100101);
    checkOutput("held32_h1", h1, 8'b00001101);
    idle(1);

    // Back-pressure: the second byte must wait in place until the slot is popped.
    evt_ready = 1'b0;
    applyStimulus(8'h45);
    byte_valid = 1'b1; byte_data = 8'h46;
    idle(3);
    checkOutput("stall_ready", byte_ready, 0);
    checkOutput("stall_code", evt_code, 8'h45);
    evt_ready = 1'b1;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    checkOutput("unstall_evt", {evt_valid, evt_code, evt_make}, {1'b1, 8'h46, 1'b1});
    idle(1);

    applyStimulus(8'hE0); applyStimulus(8'hF0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_valid", evt_valid, 0);
    checkOutput("midrst_down", key_down, 0);
    checkOutput("midrst_h1", h1, 8'hFF);
    rst = 1'b1;
    applyStimulus(8'h75);
    checkOutput("post_rst_evt", {evt_valid, evt_code, evt_ext, evt_make}, {1'b1, 8'h75, 1'b0, 1'b1});
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
